// File: rtl/pkg_processador.sv
// Shared definitions for the processor datapath: ALU op codes and the
// FSM state encoding used by the ALU arbiter.
package pkg_processador;

  // ALU operation codes (sinal_ula encoding)
  localparam logic [2:0] OP_AND        = 3'b000;
  localparam logic [2:0] OP_OR         = 3'b001;
  localparam logic [2:0] OP_ADD        = 3'b010;
  localparam logic [2:0] OP_SUB        = 3'b011;
  localparam logic [2:0] OP_SLT        = 3'b100;
  localparam logic [2:0] OP_MAX_VALIDO = 3'b100;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  // Codes above the last defined op are still forwarded, but flagged.
  function automatic logic op_invalido(input logic [2:0] op);
    return op > OP_MAX_VALIDO;
  endfunction

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin grant. prioridade=0 favours requester 0 on a
// conflict, prioridade=1 favours requester 1. A lone request always wins.
module arbitro_rr2 (
  input  logic valido0,
  input  logic valido1,
  input  logic prioridade,
  output logic grant0,
  output logic grant1
);

  // Grant the only requester, or the favoured one when both ask
  assign grant0 = valido0 & (~valido1 | ~prioridade);
  assign grant1 = valido1 & (~valido0 |  prioridade);

endmodule

// File: rtl/arbitro_ula.sv
// Shares one ALU between two requesters. A request is captured in OCIOSO,
// the ALU is driven from the captured operands in EXECUTA, and the
// registered result is offered to the granted requester in RESPONDE.
module arbitro_ula
  import pkg_processador::*;
#(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset,
  // requester 0 (main control unit)
  input  logic               req0_valido,
  output logic               req0_pronto,
  input  logic [LARGURA-1:0] req0_a,
  input  logic [LARGURA-1:0] req0_b,
  input  logic [2:0]         req0_op,
  output logic               resp0_valido,
  input  logic               resp0_pronto,
  output logic [LARGURA-1:0] resp0_resultado,
  output logic               resp0_zero,
  output logic               resp0_erro,
  // requester 1 (address/branch-compare path)
  input  logic               req1_valido,
  output logic               req1_pronto,
  input  logic [LARGURA-1:0] req1_a,
  input  logic [LARGURA-1:0] req1_b,
  input  logic [2:0]         req1_op,
  output logic               resp1_valido,
  input  logic               resp1_pronto,
  output logic [LARGURA-1:0] resp1_resultado,
  output logic               resp1_zero,
  output logic               resp1_erro,
  // ALU side
  output logic [LARGURA-1:0] ula_entrada1,
  output logic [LARGURA-1:0] ula_entrada2,
  output logic [2:0]         ula_sinal,
  input  logic [LARGURA-1:0] ula_saida,
  input  logic               ula_zero
);

  estado_t            estado, prox_estado;
  logic               prioridade;   // 0: req0 wins the next conflict
  logic               grant;        // index of the requester being served
  logic [LARGURA-1:0] a_q, b_q, res_q;
  logic [2:0]         op_q;
  logic               zero_q, erro_q;
  logic               g0, g1;
  logic               aceita, conclui;

  arbitro_rr2 u_rr (
    .valido0    (req0_valido),
    .valido1    (req1_valido),
    .prioridade (prioridade),
    .grant0     (g0),
    .grant1     (g1)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) estado <= OCIOSO;
    else       estado <= prox_estado;
  end

  // Next-state and handshake outputs
  always_comb begin
    // NOTE: every output gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    prox_estado  = estado;
    req0_pronto  = 1'b0;
    req1_pronto  = 1'b0;
    resp0_valido = 1'b0;
    resp1_valido = 1'b0;
    aceita       = 1'b0;
    conclui      = 1'b0;
    case (estado)
      OCIOSO: begin
        // reset gates pronto so nothing is accepted while it is held
        req0_pronto = g0 & ~reset;
        req1_pronto = g1 & ~reset;
        aceita      = req0_pronto | req1_pronto;
        if (aceita) prox_estado = EXECUTA;
      end
      EXECUTA: prox_estado = RESPONDE;
      RESPONDE: begin
        resp0_valido = ~grant;
        resp1_valido = grant;
        conclui      = grant ? resp1_pronto : resp0_pronto;
        if (conclui) prox_estado = OCIOSO;
      end
      default: prox_estado = OCIOSO;
    endcase
  end

  // Operand capture, result capture and round-robin priority update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prioridade <= 1'b0;
      grant      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      erro_q     <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      if (aceita) begin
        grant  <= g1;
        a_q    <= g1 ? req1_a  : req0_a;
        b_q    <= g1 ? req1_b  : req0_b;
        op_q   <= g1 ? req1_op : req0_op;
        erro_q <= op_invalido(g1 ? req1_op : req0_op);
      end
      if (estado == EXECUTA) begin
        res_q  <= ula_saida;
        zero_q <= ula_zero;
      end
      if (conclui) prioridade <= ~grant;
    end
  end

  // The ALU always sees the captured operands; its output only matters in EXECUTA
  assign ula_entrada1 = a_q;
  assign ula_entrada2 = b_q;
  assign ula_sinal    = op_q;

  // Both response ports mirror the shared result registers
  assign resp0_resultado = res_q;
  assign resp0_zero      = zero_q;
  assign resp0_erro      = erro_q;
  assign resp1_resultado = res_q;
  assign resp1_zero      = zero_q;
  assign resp1_erro      = erro_q;

endmodule

// File: tb/tb_arbitro_ula.sv
// Self-checking bench for arbitro_ula: an ALU model closes the loop, a
// monitor checks arbitration and pops a per-port scoreboard on responses.
module tb_arbitro_ula;
  import pkg_processador::*;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valido = 1'b0, req1_valido = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic         resp0_pronto = 1'b1, resp1_pronto = 1'b1;
  logic         req0_pronto, req1_pronto, resp0_valido, resp1_valido;
  logic [W-1:0] resp0_resultado, resp1_resultado;
  logic         resp0_zero, resp1_zero, resp0_erro, resp1_erro;
  logic [W-1:0] ula_entrada1, ula_entrada2, ula_saida;
  logic [2:0]   ula_sinal;
  logic         ula_zero;

  arbitro_ula #(.LARGURA(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valido(req0_valido), .req0_pronto(req0_pronto),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .resp0_valido(resp0_valido), .resp0_pronto(resp0_pronto),
    .resp0_resultado(resp0_resultado), .resp0_zero(resp0_zero), .resp0_erro(resp0_erro),
    .req1_valido(req1_valido), .req1_pronto(req1_pronto),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp1_valido(resp1_valido), .resp1_pronto(resp1_pronto),
    .resp1_resultado(resp1_resultado), .resp1_zero(resp1_zero), .resp1_erro(resp1_erro),
    .ula_entrada1(ula_entrada1), .ula_entrada2(ula_entrada2), .ula_sinal(ula_sinal),
    .ula_saida(ula_saida), .ula_zero(ula_zero)
  );

  always #5 clock = ~clock;

  // Behavioural ALU: 8-bit wrap on add/sub, unsigned slt, 0 for undefined codes
  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return (a < b) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  assign ula_saida = alu_ref(ula_sinal, ula_entrada1, ula_entrada2);
  assign ula_zero  = (ula_saida == '0);

  int checks = 0;
  int failures = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         erro;
    int           acc;
    bit           seen;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   acc_log[$];
  int   acc_cyc[$];
  int   cyc = 0;
  bit   busy = 0;
  bit   pri = 0;   // 1 after req0 was served last: req1 wins the next conflict
  bit   g0_esp, g1_esp;

  function automatic exp_t esperado(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    exp_t e;
    e.res  = alu_ref(op, a, b);
    e.zero = (e.res == '0);
    e.erro = (op > 3'b100);
    e.acc  = cyc;
    e.seen = 0;
    return e;
  endfunction

  task automatic tratar_resp(input int p, input logic v, input logic pr,
                             input logic [W-1:0] r, input logic z, input logic e);
    exp_t ex;
    if (!v) return;
    if ((p == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      check($sformatf("resp%0d_valido_sem_pedido", p), v, 1'b0);
      return;
    end
    ex = (p == 0) ? q0[0] : q1[0];
    if (!ex.seen) begin
      check($sformatf("latencia%0d", p), cyc - ex.acc, 2);
      if (p == 0) q0[0].seen = 1; else q1[0].seen = 1;
    end
    check($sformatf("resultado%0d", p), r, ex.res);
    check($sformatf("zero%0d", p), z, ex.zero);
    check($sformatf("erro%0d", p), e, ex.erro);
    if (pr) begin
      if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      busy = 0;
      pri  = (p == 0);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      check("pronto0_em_reset", req0_pronto, 1'b0);
      check("pronto1_em_reset", req1_pronto, 1'b0);
      check("valido0_em_reset", resp0_valido, 1'b0);
      check("valido1_em_reset", resp1_valido, 1'b0);
      q0.delete();
      q1.delete();
      busy = 0;
      pri  = 0;
    end else begin
      g0_esp = !busy && req0_valido && (!req1_valido || !pri);
      g1_esp = !busy && req1_valido && (!req0_valido || pri);
      check("pronto0", req0_pronto, g0_esp);
      check("pronto1", req1_pronto, g1_esp);
      tratar_resp(0, resp0_valido, resp0_pronto, resp0_resultado, resp0_zero, resp0_erro);
      tratar_resp(1, resp1_valido, resp1_pronto, resp1_resultado, resp1_zero, resp1_erro);
      if (req0_pronto && req0_valido) begin
        q0.push_back(esperado(req0_op, req0_a, req0_b));
        busy = 1;
        acc_log.push_back(0);
        acc_cyc.push_back(cyc);
      end
      if (req1_pronto && req1_valido) begin
        q1.push_back(esperado(req1_op, req1_a, req1_b));
        busy = 1;
        acc_log.push_back(1);
        acc_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic ciclos(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present one request, hold it until accepted, then release it and scramble operands
  task automatic emitir(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op);
    int n = 0;
    logic pr;
    if (p == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valido = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_op = op; req1_valido = 1'b1; end
    do begin
      @(negedge clock);
      n++;
      pr = ((p == 0) ? req0_pronto : req1_pronto) & ~reset;
    end while (!pr && n < 300);
    if (!pr) check($sformatf("aceite%0d_timeout", p), pr, 1'b1);
    @(posedge clock);
    #1;
    if (p == 0) begin req0_valido = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 3'($urandom); end
    else        begin req1_valido = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 3'($urandom); end
  endtask

  task automatic drenar();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      ciclos(1);
      n++;
    end
    check("drenagem", q0.size() + q1.size(), 0);
    ciclos(2);
  endtask

  bit random_fim = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Conflict from reset: both valid while reset is high, req0 must win first
    req0_a = 8'h0F; req0_b = 8'hF0; req0_op = OP_AND; req0_valido = 1'b1;
    req1_a = 8'd5;  req1_b = 8'd7;  req1_op = OP_SUB; req1_valido = 1'b1;
    ciclos(3);
    check("rst_resultado", resp0_resultado, 8'h00);
    check("rst_ula_sinal", ula_sinal, 3'b000);
    reset = 1'b0;
    fork
      begin
        emitir(0, 8'h0F, 8'hF0, OP_AND);
        emitir(0, 8'h33, 8'h44, OP_OR);  // re-request: conflicts with waiting req1
      end
      emitir(1, 8'd5, 8'd7, OP_SUB);
    join
    drenar();
    check("conflito_n", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      check("conflito_1o", acc_log[0], 0);
      check("conflito_2o", acc_log[1], 1);
      check("conflito_3o", acc_log[2], 0);
    end

    // Single add with wrap: 200+100 -> 44
    emitir(0, 8'd200, 8'd100, OP_ADD);
    drenar();

    // Backpressure on port 1 while req0 waits
    resp1_pronto = 1'b0;
    emitir(1, 8'h01, 8'h80, OP_SLT);
    fork
      emitir(0, 8'h12, 8'h34, OP_ADD);
    join_none
    ciclos(6);
    check("bp_valido1_mantido", resp1_valido, 1'b1);
    check("bp_resultado1", resp1_resultado, 8'h01);
    resp1_pronto = 1'b1;
    wait fork;
    drenar();

    // Undefined op code: result 0, zero 1, erro 1
    emitir(0, 8'hA5, 8'h5A, 3'b110);
    drenar();

    // Asynchronous reset while EXECUTA: everything drops, no response follows
    emitir(0, 8'h81, 8'h7E, OP_ADD);
    #2;
    reset = 1'b1;
    #1;
    check("rstx_pronto0", req0_pronto, 1'b0);
    check("rstx_valido0", resp0_valido, 1'b0);
    check("rstx_zero0", resp0_zero, 1'b0);
    check("rstx_erro0", resp0_erro, 1'b0);
    check("rstx_resultado0", resp0_resultado, 8'h00);
    check("rstx_entrada1", ula_entrada1, 8'h00);
    check("rstx_entrada2", ula_entrada2, 8'h00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    ciclos(5);
    acc_log.delete();
    fork
      emitir(0, 8'h10, 8'h20, OP_ADD);
      emitir(1, 8'h30, 8'h40, OP_SUB);
    join
    drenar();
    check("pos_reset_n", acc_log.size(), 2);
    if (acc_log.size() == 2) check("pos_reset_1o", acc_log[0], 0);

    // Back-to-back stream on req0: acceptances 3 cycles apart, in order
    acc_log.delete();
    acc_cyc.delete();
    for (int i = 0; i < 4; i++)
      emitir(0, W'($urandom), W'($urandom), 3'($urandom_range(0, 4)));
    drenar();
    check("stream_n", acc_cyc.size(), 4);
    if (acc_cyc.size() == 4)
      for (int i = 0; i < 3; i++)
        check($sformatf("stream_intervalo%0d", i), acc_cyc[i+1] - acc_cyc[i], 3);

    // Randomized traffic on both ports with random response backpressure
    fork
      begin
        while (!random_fim) begin
          resp0_pronto = ($urandom_range(0, 3) != 0);
          resp1_pronto = ($urandom_range(0, 3) != 0);
          ciclos(1);
        end
      end
    join_none
    fork
      for (int i = 0; i < 30; i++) begin
        ciclos($urandom_range(0, 2));
        emitir(0, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
      end
      for (int j = 0; j < 30; j++) begin
        ciclos($urandom_range(0, 2));
        emitir(1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
      end
    join
    random_fim = 1;
    ciclos(1);
    resp0_pronto = 1'b1;
    resp1_pronto = 1'b1;
    drenar();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
